// File: rtl/load_store_unit.sv
// Load/store unit: 64-bit byte-addressed loads and stores over a doubleword
// memory port. Defining MISALIGN_TRAP_EN turns misaligned accesses into traps.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        ready,
  output logic [63:0] rdata,
  output logic        busy,
  output logic        misalign,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  func3_q;
  logic [2:0]  off_q;
  logic [63:0] wdata_q;
  logic [63:0] dword_q;
  logic        mis_q;
  logic        ready_q;
  logic        busy_q;
  logic        mem_wr_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;
  logic [63:0] rdata_q;
  logic        trap_s;

  function automatic logic [2:0] eff_offset(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b00:   eff_offset = off;
      2'b01:   eff_offset = {off[2:1], 1'b0};
      2'b10:   eff_offset = {off[2], 2'b00};
      default: eff_offset = 3'b000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off[1:0];
      2'b11:   is_misaligned = |off;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] load_extract(input logic [63:0] dw, input logic [2:0] off,
                                               input logic [2:0] f3);
    logic [63:0] sh;
    sh = dw >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{56{sh[7]}}, sh[7:0]};
      3'b001:  load_extract = {{48{sh[15]}}, sh[15:0]};
      3'b010:  load_extract = {{32{sh[31]}}, sh[31:0]};
      3'b100:  load_extract = {56'h0, sh[7:0]};
      3'b101:  load_extract = {48'h0, sh[15:0]};
      3'b110:  load_extract = {32'h0, sh[31:0]};
      default: load_extract = sh;
    endcase
  endfunction

  function automatic logic [63:0] store_merge(input logic [63:0] dw, input logic [63:0] wd,
                                              input logic [2:0] off, input logic [1:0] size);
    logic [63:0] m;
    logic [5:0]  sa;
    sa = {off, 3'b000};
    case (size)
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    m = m << sa;
    store_merge = (dw & ~m) | ((wd << sa) & m);
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign trap_s = is_misaligned(func3[1:0], addr[2:0]);
`else
  assign trap_s = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (trap_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        if (we_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      func3_q     <= 3'b000;
      off_q       <= 3'b000;
      wdata_q     <= 64'h0;
      dword_q     <= 64'h0;
      mis_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 64'h0;
      mem_wdata_q <= 64'h0;
      rdata_q     <= 64'h0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != S_IDLE);
      mem_wr_q <= (state_d == S_WRITE);
      ready_q  <= (state_q == S_DONE);
      if (state_q == S_IDLE && req) begin
        we_q       <= we;
        func3_q    <= func3;
        off_q      <= eff_offset(func3[1:0], addr[2:0]);
        wdata_q    <= wdata;
        mem_addr_q <= {addr[63:3], 3'b000};
        mis_q      <= trap_s;
      end
      // The merged store word is formed directly from the returning read data
      if (state_q == S_WAIT) begin
        dword_q     <= mem_rdata;
        mem_wdata_q <= store_merge(mem_rdata, wdata_q, off_q, func3_q[1:0]);
      end
      if (state_q == S_DONE && !we_q && !mis_q) begin
        rdata_q <= load_extract(dword_q, off_q, func3_q);
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  // Misalignment flag accompanies the completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= (state_q == S_DONE) && mis_q;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a one-cycle-latency doubleword memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [2:0]  func3;
  logic [63:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        ready, busy, misalign, mem_wr;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .func3(func3), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .busy(busy), .misalign(misalign),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  logic [63:0] mem [0:31];
  logic [63:0] ref_mem [0:31];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [63:0] pl_dat = 64'h0;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[7:3]];
    if (pl_we) mem[pl_idx] <= pl_dat;
    else if (mem_wr) mem[mem_addr[7:3]] <= mem_wdata;
  end

  typedef struct {
    string       tag;
    logic [63:0] rd;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_count = 0;
  logic [63:0] last_wdata = 64'h0;
  logic [63:0] last_rd;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wr_count   <= wr_count + 1;
      last_wdata <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val({e.tag, "_rdata"}, rdata, e.rd);
        check_val({e.tag, "_misalign"}, {63'h0, misalign}, {63'h0, e.mis});
        check_val({e.tag, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 50 && busy !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic wait_sb(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check_val({tag, "_completed"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic do_op(input string tag, input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                       input logic exp_mis, input int exp_lat, input logic [63:0] exp_wdata,
                       input int exp_wr);
    exp_t e;
    int   wr0;
    wait_idle();
    we = w; func3 = f3; addr = a; wdata = wd; req = 1'b1;
    wr0 = wr_count;
    @(posedge clk);
    #1;
    req = 1'b0;
    e.tag = tag; e.rd = exp_rd; e.mis = exp_mis; e.lat = exp_lat; e.acc = cyc;
    sb.push_back(e);
    check_val({tag, "_mem_addr"}, mem_addr, {a[63:3], 3'b000});
    wait_sb(tag);
    check_val({tag, "_wr_pulses"}, 64'(wr_count - wr0), 64'(exp_wr));
    if (exp_wr != 0) check_val({tag, "_mem_wdata"}, last_wdata, exp_wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] seed_dw;
    exp_t        e;
    int          k, wr0;

    reset = 1'b0; req = 1'b0; we = 1'b0; func3 = 3'b000; addr = 64'h0; wdata = 64'h0;
    seed_dw = {$urandom, $urandom};
    ref_mem[16] = seed_dw;
    @(negedge clk);
    pl_we = 1'b1; pl_idx = 5'd8; pl_dat = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    pl_idx = 5'd16; pl_dat = seed_dw;
    @(negedge clk);
    pl_we = 1'b0;
    check_val("rst_ready", {63'h0, ready}, 64'd0);
    check_val("rst_busy", {63'h0, busy}, 64'd0);
    check_val("rst_misalign", {63'h0, misalign}, 64'd0);
    check_val("rst_mem_wr", {63'h0, mem_wr}, 64'd0);
    check_val("rst_rdata", rdata, 64'h0);
    reset = 1'b1;

    do_op("lb_41", 1'b0, 3'b000, 64'h41, 64'h0, 64'hFFFF_FFFF_FFFF_FFCD, 1'b0, 3, 64'h0, 0);
    do_op("lhu_46", 1'b0, 3'b101, 64'h46, 64'h0, 64'h0000_0000_0000_0123, 1'b0, 3, 64'h0, 0);
    do_op("lw_40", 1'b0, 3'b010, 64'h40, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 3, 64'h0, 0);
    last_rd = 64'hFFFF_FFFF_89AB_CDEF;
    do_op("sb_43", 1'b1, 3'b000, 64'h43, 64'hAA, last_rd, 1'b0, 4, 64'h0123_4567_AAAB_CDEF, 1);
    do_op("ld_after_sb", 1'b0, 3'b111, 64'h40, 64'h0, 64'h0123_4567_AAAB_CDEF, 1'b0, 3, 64'h0, 0);
    last_rd = 64'h0123_4567_AAAB_CDEF;
    do_op("sd_40", 1'b1, 3'b011, 64'h40, 64'h0123_4567_89AB_CDEF, last_rd, 1'b0, 4,
          64'h0123_4567_89AB_CDEF, 1);
`ifdef MISALIGN_TRAP_EN
    do_op("lw_42_trap", 1'b0, 3'b010, 64'h42, 64'h0, last_rd, 1'b1, 1, 64'h0, 0);
    do_op("sh_41_trap", 1'b1, 3'b001, 64'h41, 64'hBEEF, last_rd, 1'b1, 1, 64'h0, 0);
`else
    do_op("lw_42", 1'b0, 3'b010, 64'h42, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 3, 64'h0, 0);
    last_rd = 64'hFFFF_FFFF_89AB_CDEF;
    do_op("sh_41", 1'b1, 3'b001, 64'h41, 64'hBEEF, last_rd, 1'b0, 4, 64'h0123_4567_89AB_BEEF, 1);
    do_op("sd_restore", 1'b1, 3'b011, 64'h40, 64'h0123_4567_89AB_CDEF, last_rd, 1'b0, 4,
          64'h0123_4567_89AB_CDEF, 1);
`endif
    check_val("mem_40_final", mem[8], 64'h0123_4567_89AB_CDEF);

    // req pulses while busy must be ignored
    wait_idle();
    we = 1'b0; func3 = 3'b010; addr = 64'h44; req = 1'b1;
    wr0 = wr_count;
    @(posedge clk);
    #1;
    req = 1'b0;
    e.tag = "lw_44_ign"; e.rd = 64'h0000_0000_0123_4567; e.mis = 1'b0; e.lat = 3; e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; we = 1'b1; func3 = 3'b000; addr = 64'h48;
    @(negedge clk);
    req = 1'b0;
    wait_sb("lw_44_ign");
    repeat (6) @(posedge clk);
    check_val("ign_no_write", 64'(wr_count - wr0), 64'd0);
    last_rd = 64'h0000_0000_0123_4567;

    // back-to-back with req held high
    wait_idle();
    we = 1'b0; func3 = 3'b011; addr = 64'h40; req = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    e.tag = "b2b_ld"; e.rd = 64'h0123_4567_89AB_CDEF; e.mis = 1'b0; e.lat = 3; e.acc = k;
    sb.push_back(e);
    func3 = 3'b000; addr = 64'h41;
    repeat (3) @(posedge clk);
    #1;
    check_val("b2b_idle_gap", {63'h0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check_val("b2b_second_accept", {63'h0, busy}, 64'd1);
    req = 1'b0;
    e.tag = "b2b_lb"; e.rd = 64'hFFFF_FFFF_FFFF_FFCD; e.mis = 1'b0; e.lat = 3; e.acc = k + 4;
    sb.push_back(e);
    wait_sb("b2b");
    last_rd = 64'hFFFF_FFFF_FFFF_FFCD;

    // reset during WAIT of a doubleword store
    wait_idle();
    we = 1'b1; func3 = 3'b011; addr = 64'h40; wdata = 64'hFFEE_DDCC_BBAA_9988; req = 1'b1;
    wr0 = wr_count;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("midrst_busy", {63'h0, busy}, 64'd0);
    check_val("midrst_mem_wr", {63'h0, mem_wr}, 64'd0);
    check_val("midrst_ready", {63'h0, ready}, 64'd0);
    check_val("midrst_rdata", rdata, 64'h0);
    check_val("midrst_misalign", {63'h0, misalign}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    check_val("midrst_no_write", 64'(wr_count - wr0), 64'd0);
    check_val("midrst_mem", mem[8], 64'h0123_4567_89AB_CDEF);
    do_op("ld_after_rst", 1'b0, 3'b011, 64'h40, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 64'h0, 0);
    last_rd = 64'h0123_4567_89AB_CDEF;

    // naturally aligned random traffic within doubleword 0x80
    for (int i = 0; i < 14; i++) begin
      logic        w;
      logic [2:0]  f3;
      logic [2:0]  off;
      logic [63:0] a, wd, ev;
      int          n;
      w   = 1'($urandom_range(0, 1));
      f3  = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      n   = 1 << f3[1:0];
      off = 3'($urandom_range(0, 7)) & ~3'(n - 1);
      a   = {61'h10, off};
      wd  = {$urandom, $urandom};
      if (w) begin
        for (int b = 0; b < n; b++) ref_mem[16][8*(off+b) +: 8] = wd[8*b +: 8];
        do_op("rnd_st", 1'b1, f3, a, wd, last_rd, 1'b0, 4, ref_mem[16], 1);
      end else begin
        ev = 64'h0;
        for (int b = 0; b < n; b++) ev[8*b +: 8] = ref_mem[16][8*(off+b) +: 8];
        if (!f3[2] && n < 8 && ev[8*n-1]) begin
          for (int b = n; b < 8; b++) ev[8*b +: 8] = 8'hFF;
        end
        do_op("rnd_ld", 1'b0, f3, a, wd, ev, 1'b0, 3, 64'h0, 0);
        last_rd = ev;
      end
    end
    repeat (4) @(posedge clk);
    check_val("rnd_mem", mem[16], ref_mem[16]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 64-bit data and 64-bit byte address.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req  in  1  datapath access request, sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load; sampled with req.
REQ-006 func3  in  3  RISC-V funct3 size/sign code; sampled with req.
REQ-007 addr  in  64  byte address from ALUOut; sampled with req.
REQ-008 wdata  in  64  store data from register B; sampled with req.
REQ-009 ready  out  1  one-cycle completion pulse.
REQ-010 rdata  out  64  extended load result; held until next completion.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 misalign  out  1  error flag, valid with ready.
REQ-013 mem_addr  out  64  doubleword-aligned address to data memory: {addr[63:3],3'b000}.
REQ-014 mem_wdata  out  64  merged doubleword to data memory.
REQ-015 mem_wr  out  1  data memory write strobe.
REQ-016 mem_rdata  in  64  data memory read port; reflects mem_addr with one cycle latency.

Function
REQ-017 FSM states SHALL be IDLE, READ, WAIT, WRITE, DONE; encoding free.
REQ-018 IDLE with req=1 SHALL latch we, func3, addr, wdata and go to READ; req=0 stays IDLE; req outside IDLE is ignored.
REQ-019 READ SHALL drive mem_addr from the latched address and go to WAIT.
REQ-020 WAIT SHALL capture mem_rdata into an internal doubleword register; load -> DONE, store -> WRITE.
REQ-021 WRITE SHALL assert mem_wr=1 for exactly one cycle with mem_wdata = captured doubleword with the addressed lanes replaced by the low bytes of wdata, then go to DONE.
REQ-022 DONE SHALL assert ready=1 for one cycle and return to IDLE; mem_wr SHALL be 0 in all states except WRITE.
REQ-023 Latency: req accepted at edge k -> ready high in the cycle after edge k+3 for loads and edge k+4 for stores; back-to-back req accepted in the IDLE cycle right after DONE.
REQ-024 Byte order little-endian; lane offset = addr[2:0].
REQ-025 Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; signed forms sign-extend, unsigned zero-extend to 64 bits; 111 SHALL behave as 011.
REQ-026 Stores use func3[1:0] only: 00 SB, 01 SH, 10 SW, 11 SD.
REQ-027 rdata SHALL update only on load completion; stores leave rdata unchanged.
REQ-028 Natural alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0; B always aligned.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, ready=0, busy=0, misalign=0, mem_wr=0, rdata=0 and clear all latched request registers, also mid-operation.
REQ-030 An interrupted store SHALL never assert mem_wr after reset deasserts; the first req after deassertion SHALL be accepted normally.

Configuration
REQ-031 Macro MISALIGN_TRAP_EN defined: misaligned accepted req SHALL go IDLE -> DONE directly, ready with misalign=1, no memory read, mem_wr never asserted, rdata unchanged.
REQ-032 Macro MISALIGN_TRAP_EN undefined: misalign SHALL be tied 0 and the offset bits below the access size SHALL be forced to zero before lane selection.

Verification
REQ-033 Preload 0x40 = 0x0123456789ABCDEF; LB addr 0x41 -> ready 3 cycles after accept, rdata = 0xFFFFFFFFFFFFFFCD.
REQ-034 Same preload; LHU addr 0x46 -> rdata = 0x0000000000000123; LW addr 0x40 -> rdata = 0xFFFFFFFF89ABCDEF.
REQ-035 Same preload; SB addr 0x43, wdata 0x00000000000000AA -> single mem_wr pulse, mem_wdata = 0x01234567AAABCDEF; ready 4 cycles after accept; rdata unchanged.
REQ-036 LW addr 0x42: with MISALIGN_TRAP_EN -> ready 1 cycle after accept, misalign=1, no mem_wr; without -> rdata = 0xFFFFFFFF89ABCDEF, misalign=0.
REQ-037 SD addr 0x40 accepted, reset pulsed low during WAIT -> busy=0 and mem_wr=0 immediately, memory still 0x0123456789ABCDEF; next LD addr 0x40 completes normally.
REQ-038 req held high continuously for LD then LB -> second accepted in the IDLE cycle after the first DONE; req pulses during busy are ignored.
